// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int unsigned ASIZE = 5,
  parameter int unsigned CSIZE = 16
);
  logic [ASIZE-1:0] id_rs1;
  logic [ASIZE-1:0] id_rs2;
  logic             id_uses_rs2;
  logic [ASIZE-1:0] exe_waddr;
  logic             exe_wen;
  logic             exe_mem_read;
  logic [ASIZE-1:0] mem_waddr;
  logic             mem_wen;
  logic             ex_branch_taken;
  logic             ext_stall;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_exe_en;
  logic             id_exe_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CSIZE-1:0] stall_cnt;
  logic [CSIZE-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, exe_waddr, exe_wen, exe_mem_read,
           mem_waddr, mem_wen, ex_branch_taken, ext_stall,
    input  pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, exe_waddr, exe_wen, exe_mem_read,
           mem_waddr, mem_wen, ex_branch_taken, ext_stall,
    output pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, external-wait freeze,
// registered forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned ASIZE = 5,
  parameter int unsigned CSIZE = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] FREEZE   = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [ASIZE-1:0] REG_ZERO = '0;
  localparam logic [CSIZE-1:0] CNT_MAX  = '1;
  localparam logic [CSIZE-1:0] CNT_ONE  = {{(CSIZE-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [1:0]       w_sel_a;
  logic [1:0]       w_sel_b;
  logic [CSIZE-1:0] r_stall_cnt;
  logic [CSIZE-1:0] r_flush_cnt;

  logic w_exe_fwd_ok;
  logic w_mem_fwd_ok;
  logic w_lu_hit;
  logic w_freeze;
  logic w_flush;
  logic w_stall;

  assign w_exe_fwd_ok = hz.exe_wen & (hz.exe_waddr != REG_ZERO);
  assign w_mem_fwd_ok = hz.mem_wen & (hz.mem_waddr != REG_ZERO);

  assign w_lu_hit = w_exe_fwd_ok & hz.exe_mem_read &
                    ((hz.exe_waddr == hz.id_rs1) |
                     (hz.id_uses_rs2 & (hz.exe_waddr == hz.id_rs2)));

  // Priority: external wait, then taken branch, then load-use. In LU_STALL the EXE
  // stage already holds the bubble, so a lingering lu_hit must not stall again.
  assign w_freeze = hz.ext_stall;
  assign w_flush  = ~hz.ext_stall & hz.ex_branch_taken;
  assign w_stall  = ~hz.ext_stall & ~hz.ex_branch_taken & w_lu_hit & (r_state != LU_STALL);

  always_comb begin
    w_sel_a = FWD_RF;
    if (w_exe_fwd_ok && (hz.exe_waddr == hz.id_rs1)) begin
      w_sel_a = FWD_EXE;
    end else if (w_mem_fwd_ok && (hz.mem_waddr == hz.id_rs1)) begin
      w_sel_a = FWD_MEM;
    end
  end

  always_comb begin
    w_sel_b = FWD_RF;
    if (hz.id_uses_rs2) begin
      if (w_exe_fwd_ok && (hz.exe_waddr == hz.id_rs2)) begin
        w_sel_b = FWD_EXE;
      end else if (w_mem_fwd_ok && (hz.mem_waddr == hz.id_rs2)) begin
        w_sel_b = FWD_MEM;
      end
    end
  end

  always_comb begin
    w_state_nxt = RUN;
    if (w_freeze) begin
      w_state_nxt = FREEZE;
    end else if (w_stall) begin
      w_state_nxt = LU_STALL;
    end
  end

  // Reset is applied combinationally too so the pipe is held the instant rst_n drops.
  always_comb begin
    hz.pc_en         = 1'b1;
    hz.if_id_en      = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_exe_en     = 1'b1;
    hz.id_exe_bubble = 1'b0;
    if (!rst_n) begin
      hz.pc_en         = 1'b0;
      hz.if_id_en      = 1'b0;
      hz.if_id_flush   = 1'b1;
      hz.id_exe_bubble = 1'b1;
    end else if (w_freeze) begin
      hz.pc_en     = 1'b0;
      hz.if_id_en  = 1'b0;
      hz.id_exe_en = 1'b0;
    end else if (w_flush) begin
      hz.if_id_flush   = 1'b1;
      hz.id_exe_bubble = 1'b1;
    end else if (w_stall) begin
      hz.pc_en         = 1'b0;
      hz.if_id_en      = 1'b0;
      hz.id_exe_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_freeze) begin
        if (w_flush || w_stall) begin
          r_fwd_a <= FWD_RF;
          r_fwd_b <= FWD_RF;
        end else begin
          r_fwd_a <= w_sel_a;
          r_fwd_b <= w_sel_b;
        end
      end
      if (w_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign hz.fwd_a     = r_fwd_a;
  assign hz.fwd_b     = r_fwd_b;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a cycle-level
// model of the hazard rules (one bubble per load-use, branch flush, freeze on wait).
module tb_hazard_ctrl;

  localparam int unsigned ASIZE   = 5;
  localparam int unsigned CSIZE   = 4;
  localparam int          CNT_MAX = (1 << CSIZE) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl_if #(.ASIZE(ASIZE), .CSIZE(CSIZE)) hz ();

  hazard_ctrl #(.ASIZE(ASIZE), .CSIZE(CSIZE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // Reference state: counters, latched forwarding selects, and whether the
  // previous cycle was the load-use bubble cycle.
  int m_stall_cnt;
  int m_flush_cnt;
  int m_fwd_a;
  int m_fwd_b;
  bit m_after_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stall_cnt   = 0;
    m_flush_cnt   = 0;
    m_fwd_a       = 0;
    m_fwd_b       = 0;
    m_after_stall = 1'b0;
  endtask

  // Where operand register r comes from: youngest producer wins, x0 always regfile.
  function automatic int src_of(input logic [ASIZE-1:0] r);
    if (r == 0) return 0;
    if (hz.exe_wen && hz.exe_waddr == r) return 1;
    if (hz.mem_wen && hz.mem_waddr == r) return 2;
    return 0;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pc_en"},     32'(hz.pc_en), 0);
    check({tag, "_if_id_en"},  32'(hz.if_id_en), 0);
    check({tag, "_flush"},     32'(hz.if_id_flush), 1);
    check({tag, "_id_exe_en"}, 32'(hz.id_exe_en), 1);
    check({tag, "_bubble"},    32'(hz.id_exe_bubble), 1);
    check({tag, "_fwd_a"},     32'(hz.fwd_a), 0);
    check({tag, "_fwd_b"},     32'(hz.fwd_b), 0);
    check({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 0);
    check({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 0);
  endtask

  task automatic drive(input logic [ASIZE-1:0] rs1, input logic [ASIZE-1:0] rs2,
                       input logic uses2, input logic [ASIZE-1:0] ewa, input logic ewen,
                       input logic emr, input logic [ASIZE-1:0] mwa, input logic mwen,
                       input logic br, input logic st);
    hz.id_rs1          = rs1;
    hz.id_rs2          = rs2;
    hz.id_uses_rs2     = uses2;
    hz.exe_waddr       = ewa;
    hz.exe_wen         = ewen;
    hz.exe_mem_read    = emr;
    hz.mem_waddr       = mwa;
    hz.mem_wen         = mwen;
    hz.ex_branch_taken = br;
    hz.ext_stall       = st;
  endtask

  // Called at posedge+1 with inputs driven; checks mid-cycle, advances model at the edge.
  task automatic step();
    bit hit, frz, br, stl;
    hit = hz.exe_wen && hz.exe_mem_read && hz.exe_waddr != 0 &&
          (hz.exe_waddr == hz.id_rs1 || (hz.id_uses_rs2 && hz.exe_waddr == hz.id_rs2));
    frz = hz.ext_stall;
    br  = !frz && hz.ex_branch_taken;
    stl = !frz && !br && hit && !m_after_stall;
    #4;
    check("pc_en",     32'(hz.pc_en), 32'(!(frz || stl)));
    check("if_id_en",  32'(hz.if_id_en), 32'(!(frz || stl)));
    check("flush",     32'(hz.if_id_flush), 32'(br));
    check("id_exe_en", 32'(hz.id_exe_en), 32'(!frz));
    check("bubble",    32'(hz.id_exe_bubble), 32'(br || stl));
    check("fwd_a",     32'(hz.fwd_a), m_fwd_a);
    check("fwd_b",     32'(hz.fwd_b), m_fwd_b);
    check("stall_cnt", 32'(hz.stall_cnt), m_stall_cnt);
    check("flush_cnt", 32'(hz.flush_cnt), m_flush_cnt);
    @(posedge clk);
    if (frz) begin
      m_after_stall = 1'b0;
    end else if (br) begin
      m_fwd_a = 0;
      m_fwd_b = 0;
      m_flush_cnt = (m_flush_cnt == CNT_MAX) ? CNT_MAX : m_flush_cnt + 1;
      m_after_stall = 1'b0;
    end else if (stl) begin
      m_fwd_a = 0;
      m_fwd_b = 0;
      m_stall_cnt = (m_stall_cnt == CNT_MAX) ? CNT_MAX : m_stall_cnt + 1;
      m_after_stall = 1'b1;
    end else begin
      m_fwd_a = src_of(hz.id_rs1);
      m_fwd_b = hz.id_uses_rs2 ? src_of(hz.id_rs2) : 0;
      m_after_stall = 1'b0;
    end
    #1;
  endtask

  task automatic cyc(input logic [ASIZE-1:0] rs1, input logic [ASIZE-1:0] rs2,
                     input logic uses2, input logic [ASIZE-1:0] ewa, input logic ewen,
                     input logic emr, input logic [ASIZE-1:0] mwa, input logic mwen,
                     input logic br, input logic st);
    drive(rs1, rs2, uses2, ewa, ewen, emr, mwa, mwen, br, st);
    step();
  endtask

  task automatic rand_cyc();
    cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
        5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
        5'($urandom_range(0, 3)), 1'($urandom),
        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
  endtask

  // Asynchronous reset pulse asserted at posedge+1, released one edge later.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    drive(3, 3, 1, 3, 1, 1, 3, 1, 1, 0);
    #3;
    check_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load x3 in EXE, ID reads x3: one bubble, then MEM forwarding.
    cyc(3, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    cyc(3, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    check("lu_fwd_a", 32'(hz.fwd_a), 2);
    check("lu_stall_cnt", 32'(hz.stall_cnt), 1);

    // ALU writer of x5 feeds rs2; x0 never forwards.
    cyc(0, 5, 1, 5, 1, 0, 0, 0, 0, 0);
    check("alu_fwd_b", 32'(hz.fwd_b), 1);
    cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("x0_fwd_b", 32'(hz.fwd_b), 0);

    // Taken branch overrides a coincident load-use.
    cyc(3, 0, 0, 3, 1, 1, 0, 0, 1, 0);
    check("br_stall_cnt", 32'(hz.stall_cnt), 1);
    check("br_flush_cnt", 32'(hz.flush_cnt), 1);

    // External wait over a load-use: freeze 3 cycles, then exactly one bubble.
    repeat (3) cyc(3, 0, 0, 3, 1, 1, 0, 0, 0, 1);
    cyc(3, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    cyc(3, 0, 0, 3, 1, 1, 0, 0, 0, 0);
    check("frz_stall_cnt", 32'(hz.stall_cnt), 2);

    // Reset while in the bubble cycle, then a fresh load-use stalls normally.
    cyc(7, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    pulse_reset("rst_lu");
    cyc(7, 0, 0, 7, 1, 1, 0, 0, 0, 0);
    check("rst_lu_stall_cnt", 32'(hz.stall_cnt), 1);

    // Flush counter saturates rather than wrapping.
    repeat (CNT_MAX + 2) cyc(1, 2, 1, 0, 0, 0, 0, 0, 1, 0);
    check("flush_sat", 32'(hz.flush_cnt), CNT_MAX);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) pulse_reset("rst_rand");
      rand_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
